// File: rtl/lut_sequencer.sv
// rtl/lut_sequencer.sv - 16x8 program lookup table with init fill, boot load and registered reads
//
// Ports:
//   Clk, Reset         clock and synchronous active-high reset
//   ld_valid/ld_key/ld_value/ld_last, ld_ready   loader write handshake
//   rd_req/rd_key      datapath read request
//   rd_valid/rd_value  registered read response (one-cycle latency)
//   tbl_ready          table programmed, serving reads
module lut_sequencer #(
    parameter int               KEY_W    = 4,
    parameter int               VAL_W    = 8,
    parameter logic [VAL_W-1:0] INIT_VAL = 8'hFF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ld_valid,
    input  logic [KEY_W-1:0] ld_key,
    input  logic [VAL_W-1:0] ld_value,
    input  logic             ld_last,
    output logic             ld_ready,
    input  logic             rd_req,
    input  logic [KEY_W-1:0] rd_key,
    output logic             rd_valid,
    output logic [VAL_W-1:0] rd_value,
    output logic             tbl_ready
);

    localparam int DEPTH = 1 << KEY_W;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [VAL_W-1:0]   mem_q [DEPTH];
    logic [VAL_W-1:0]   mem_d [DEPTH];
    logic               rd_valid_q, rd_valid_d;
    logic [VAL_W-1:0]   rd_value_q, rd_value_d;

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        mem_d      = mem_q;
        rd_valid_d = 1'b0;
        rd_value_d = rd_value_q;
        ld_ready   = 1'b0;
        tbl_ready  = 1'b0;

        case (state_q)
            ST_INIT: begin
                mem_d[fill_cnt_q] = INIT_VAL;
                fill_cnt_d        = fill_cnt_q + 1'b1;
                if (fill_cnt_q == {KEY_W{1'b1}}) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_d[ld_key] = ld_value;
                    if (ld_last) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                tbl_ready = 1'b1;
                // The table has a single access slot per cycle; a read owns it
                // and any pending loader write waits for an idle read cycle.
                ld_ready  = ~rd_req;
                if (rd_req) begin
                    rd_valid_d = 1'b1;
                    rd_value_d = mem_q[rd_key];
                end else if (ld_valid) begin
                    mem_d[ld_key] = ld_value;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Table contents are not cleared by Reset; the INIT fill rewrites them.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            fill_cnt_q <= '0;
            rd_valid_q <= 1'b0;
            rd_value_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_value_q <= rd_value_d;
            mem_q      <= mem_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_value = rd_value_q;

endmodule

// File: tb/tb_lut_sequencer.sv
// tb/tb_lut_sequencer.sv - self-checking bench for lut_sequencer with a table reference model
module tb_lut_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       ld_valid = 1'b0;
    logic [3:0] ld_key = '0;
    logic [7:0] ld_value = '0;
    logic       ld_last = 1'b0;
    logic       ld_ready;
    logic       rd_req = 1'b0;
    logic [3:0] rd_key = '0;
    logic       rd_valid;
    logic [7:0] rd_value;
    logic       tbl_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0] tbl_m [16];
    logic [7:0] last_rd;

    lut_sequencer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ld_valid  (ld_valid),
        .ld_key    (ld_key),
        .ld_value  (ld_value),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .rd_req    (rd_req),
        .rd_key    (rd_key),
        .rd_valid  (rd_valid),
        .rd_value  (rd_value),
        .tbl_ready (tbl_ready)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // 16 fill cycles with ld_ready low, then LOAD with ld_ready high.
    task automatic wait_fill();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ld_ready !== 1'b0 || tbl_ready !== 1'b0) begin
                errors++;
                $display("FAIL fill_ld_ready cycle %0d: ld_ready=%b tbl_ready=%b, required 0/0", i + 1, ld_ready, tbl_ready);
            end
            tick();
        end
        checks++;
        if (ld_ready !== 1'b1 || tbl_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ld_ready: ld_ready=%b tbl_ready=%b, required 1/0", ld_ready, tbl_ready);
        end
        for (int k = 0; k < 16; k++) tbl_m[k] = 8'hFF;
        last_rd = 8'h00;
    endtask

    task automatic pulse_reset_and_check(input string tag);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_value !== 8'h00 || tbl_ready !== 1'b0 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s: rd_valid=%b rd_value=%h tbl_ready=%b ld_ready=%b, required 0/00/0/0",
                     tag, rd_valid, rd_value, tbl_ready, ld_ready);
        end
    endtask

    task automatic ld_write(input logic [3:0] k, input logic [7:0] v, input logic last);
        ld_valid = 1'b1;
        ld_key   = k;
        ld_value = v;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tbl_m[k] = v;
    endtask

    task automatic read_all(input string tag);
        rd_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rd_key = 4'(k);
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_value !== tbl_m[k]) begin
                errors++;
                $display("FAIL %s key %0d: rd_valid=%b rd_value=%h, required 1/%h", tag, k, rd_valid, rd_value, tbl_m[k]);
            end
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_value !== tbl_m[15]) begin
            errors++;
            $display("FAIL %s idle: rd_valid=%b rd_value=%h, required 0/%h", tag, rd_valid, rd_value, tbl_m[15]);
        end
        last_rd = tbl_m[15];
    endtask

    task automatic test_reset();
        pulse_reset_and_check("reset_outputs");
        wait_fill();
    endtask

    task automatic test_single_load();
        ld_write(4'd3, 8'h5A, 1'b1);
        checks++;
        if (tbl_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_load_tbl_ready: got %b, required 1", tbl_ready);
        end
        read_all("single_load_read");
    endtask

    task automatic test_full_load();
        pulse_reset_and_check("full_load_reset");
        wait_fill();
        for (int k = 0; k < 16; k++) begin
            ld_write(4'(k), 8'(k * 8'h11), k == 15);
            checks++;
            if (tbl_ready !== (k == 15)) begin
                errors++;
                $display("FAIL full_load_tbl_ready after key %0d: got %b, required %b", k, tbl_ready, k == 15);
            end
        end
        read_all("full_load_read");
    endtask

    task automatic test_read_priority();
        rd_req   = 1'b1;
        rd_key   = 4'd7;
        ld_valid = 1'b1;
        ld_key   = 4'd7;
        ld_value = 8'hC3;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (ld_ready !== 1'b0) begin
                errors++;
                $display("FAIL prio_stall %0d: ld_ready=%b, required 0", i, ld_ready);
            end
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_value !== tbl_m[7]) begin
                errors++;
                $display("FAIL prio_old_value %0d: rd_valid=%b rd_value=%h, required 1/%h", i, rd_valid, rd_value, tbl_m[7]);
            end
        end
        rd_req = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_release: ld_ready=%b, required 1", ld_ready);
        end
        tick();
        ld_valid = 1'b0;
        tbl_m[7] = 8'hC3;
        rd_req = 1'b1;
        rd_key = 4'd7;
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_value !== 8'hC3) begin
            errors++;
            $display("FAIL prio_new_value: rd_valid=%b rd_value=%h, required 1/c3", rd_valid, rd_value);
        end
        last_rd = 8'hC3;
    endtask

    task automatic test_load_ignores();
        pulse_reset_and_check("load_ign_reset");
        wait_fill();
        rd_req = 1'b1;
        rd_key = 4'd2;
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_read_ignored: rd_valid=%b, required 0", rd_valid);
        end
        ld_last = 1'b1;
        tick();
        ld_last = 1'b0;
        checks++;
        if (tbl_ready !== 1'b0 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL last_without_valid: tbl_ready=%b ld_ready=%b, required 0/1", tbl_ready, ld_ready);
        end
        ld_write(4'd2, 8'h3C, 1'b1);
        checks++;
        if (tbl_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ign_finish: tbl_ready=%b, required 1", tbl_ready);
        end
    endtask

    task automatic test_random_run();
        bit         pending = 1'b0;
        bit         accepted;
        logic       exp_valid;
        logic [7:0] exp_val;
        for (int c = 0; c < 300; c++) begin
            if (!pending && ($urandom_range(0, 1) == 1)) begin
                pending  = 1'b1;
                ld_key   = 4'($urandom_range(0, 15));
                ld_value = 8'($urandom_range(0, 255));
            end
            ld_valid = pending;
            ld_last  = 1'($urandom_range(0, 1));
            rd_req   = ($urandom_range(0, 2) != 0);
            rd_key   = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (ld_ready !== !rd_req) begin
                errors++;
                $display("FAIL rand_ld_ready cycle %0d: ld_ready=%b, required %b", c, ld_ready, !rd_req);
            end
            exp_valid = rd_req;
            exp_val   = rd_req ? tbl_m[rd_key] : last_rd;
            accepted  = pending && !rd_req;
            tick();
            checks++;
            if (rd_valid !== exp_valid || rd_value !== exp_val || tbl_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_read cycle %0d: rd_valid=%b rd_value=%h tbl_ready=%b, required %b/%h/1",
                         c, rd_valid, rd_value, tbl_ready, exp_valid, exp_val);
            end
            last_rd = exp_val;
            if (accepted) begin
                tbl_m[ld_key] = ld_value;
                pending = 1'b0;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        rd_req   = 1'b0;
        tick();
    endtask

    task automatic test_reset_midway();
        pulse_reset_and_check("mid_run_reset");
        for (int i = 0; i < 7; i++) tick();
        pulse_reset_and_check("mid_fill_reset");
        wait_fill();
        ld_write(4'd5, 8'h12, 1'b0);
        ld_write(4'd9, 8'h34, 1'b0);
        pulse_reset_and_check("mid_load_reset");
        wait_fill();
        ld_write(4'd0, 8'hFF, 1'b1);
        read_all("after_reset_all_ff");
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_full_load();
        test_read_priority();
        test_load_ignores();
        test_random_run();
        test_reset_midway();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
